// File: rtl/defines_pkg.sv
// defines_pkg: shared RV32I pipeline constants, stage payload layouts and stage-register state encoding
package defines_pkg;
  localparam int XLEN = 32;
  localparam int WD_W = 5;
  localparam int OP_W = 7;
  localparam int F3_W = 3;
  localparam int EXMEM_W = WD_W + 1 + XLEN + OP_W + F3_W + XLEN;
  localparam logic [OP_W-1:0] NON_OP = 7'b0000000;
  localparam logic [F3_W-1:0] NON_FUNCT3 = 3'b000;
  typedef struct packed {
    logic [WD_W-1:0] wd;
    logic wreg;
    logic [XLEN-1:0] wdata;
    logic [OP_W-1:0] opcode;
    logic [F3_W-1:0] funct3;
    logic [XLEN-1:0] mem_addr;
  } exmem_t;
  localparam exmem_t EXMEM_NOP = '{wd: '0, wreg: 1'b0, wdata: '0, opcode: NON_OP, funct3: NON_FUNCT3, mem_addr: '0};
  localparam logic [1:0] LVL_EMPTY = 2'd0;
  localparam logic [1:0] LVL_ONE = 2'd1;
  localparam logic [1:0] LVL_TWO = 2'd2;
  typedef enum logic [1:0] {EMPTY = LVL_EMPTY, ONE = LVL_ONE, TWO = LVL_TWO} stage_state_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and rdy freeze; PIPE_STAGE_REG_SKID_EN adds a skid entry
module pipe_stage_reg
  import defines_pkg::*;
#(
  parameter int WIDTH = EXMEM_W,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  stage_state_t st, st_nx;
  logic [WIDTH-1:0] main_q, main_nx;
  logic push, pop;
  assign out_valid = st != EMPTY;
  assign out_data = main_q;
  assign level = st;
  assign push = in_valid & in_ready & rdy;
  assign pop = out_valid & out_ready & rdy;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_nx;
  assign in_ready = st != TWO;
  // next state and register contents for the two-entry skid variant
  always_comb begin
    st_nx = st;
    main_nx = main_q;
    skid_nx = skid_q;
    if (flush) begin
      st_nx = EMPTY;
      main_nx = RESET_DATA;
      skid_nx = RESET_DATA;
    end else begin
      case (st)
        EMPTY: if (push) begin
          st_nx = ONE;
          main_nx = in_data;
        end
        ONE: if (push && pop) main_nx = in_data;
        else if (pop) begin
          st_nx = EMPTY;
          main_nx = RESET_DATA;
        end else if (push) begin
          st_nx = TWO;
          skid_nx = in_data;
        end
        TWO: if (pop) begin
          st_nx = ONE;
          main_nx = skid_q;
          skid_nx = RESET_DATA;
        end
        default: st_nx = EMPTY;
      endcase
    end
  end
  // state and payload registers; rdy=0 holds because push/pop are gated by rdy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= EMPTY;
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      st <= st_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;
  // next state for the single-entry variant; a push while full always coincides with a pop
  always_comb begin
    st_nx = st;
    main_nx = main_q;
    if (flush) begin
      st_nx = EMPTY;
      main_nx = RESET_DATA;
    end else if (push) begin
      st_nx = ONE;
      main_nx = in_data;
    end else if (pop) begin
      st_nx = EMPTY;
      main_nx = RESET_DATA;
    end
  end
  // state and payload registers; rdy=0 holds because push/pop are gated by rdy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= EMPTY;
      main_q <= RESET_DATA;
    end else begin
      st <= st_nx;
      main_q <= main_nx;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model scoreboard bench for pipe_stage_reg (follows PIPE_STAGE_REG_SKID_EN)
module tb_pipe_stage_reg;
  localparam int W = 80;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0] level;
  logic [W-1:0] exp_q[$];
  logic exp_ir = 1'b1;
  logic mon_en = 1'b0;
  logic acc;
  int n_cmp = 0;
  int n_bad = 0;
  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always begin : monitor
    int sz;
    @(negedge clk);
    #1;
    if (mon_en) begin
      sz = exp_q.size();
      chk("level", W'(level), W'(sz));
      chk("out_valid", W'(out_valid), W'(sz != 0));
      chk("out_data", out_data, sz != 0 ? exp_q[0] : '0);
      exp_ir = (CAP == 2) ? (sz < 2) : (sz == 0 || out_ready);
      chk("in_ready", W'(in_ready), W'(exp_ir));
      if (flush) exp_q.delete();
      else if (sz != 0 && out_ready && rdy) void'(exp_q.pop_front());
    end
  end
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic r, input logic fl, output logic ok);
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    rdy = r;
    flush = fl;
    #2;
    ok = iv && r && !fl && exp_ir;
    if (ok) exp_q.push_back(d);
  endtask
  task automatic send(input logic [W-1:0] d, input logic ordy);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) cyc(1'b1, d, ordy, 1'b1, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_timeout: got not accepted want accepted data %h", d);
    end
  endtask
  initial begin
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_level", W'(level), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    #2 rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 1; i <= 10; i++) cyc(1'b1, W'(i), 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('hA), 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('hB), 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('hC), 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('hC), 1'b0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    if (CAP == 2) send(W'('hC), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('h11), 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('h22), 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b1, W'('h55), 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    send(W'('h77), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, W'('h99), 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(3, 0) != 0, {$urandom, $urandom, $urandom}, i % 100 < 50 ? $urandom_range(3, 0) == 0 : $urandom_range(3, 0) != 0,
          $urandom_range(7, 0) != 0, $urandom_range(29, 0) == 0, acc);
    send(W'('hA1), 1'b0);
    cyc(1'b1, W'('hA2), 1'b0, 1'b1, 1'b0, acc);
    @(negedge clk);
    mon_en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", W'(out_valid), '0);
    chk("async_rst_level", W'(level), '0);
    chk("async_rst_out_data", out_data, '0);
    exp_q.delete();
    exp_ir = 1'b1;
    @(negedge clk);
    #3 rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(i + 'h30), 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
